bus_arbiter_n: RTL and testbench
================================

Name: bus_arbiter_n

Overview:
- N-channel, parametrised successor to the two-master DRAM bus arbiter.
- Lets NUM_CH masters (CPU data port, instruction fetch, video, DMA, …) share one sdram_controller.
- Fair round-robin grant; exactly one outstanding DRAM transaction at a time.
- Completion status and read data are returned to the granted channel only.

Parameters:
- NUM_CH, 4, number of master channels (2..8).
- ADDR_W, 24, DRAM word address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz domain.
- rst  in  1  synchronous, active-high reset.
- ch_addr  in  NUM_CH*ADDR_W  packed per-channel address; channel i at [i*ADDR_W +: ADDR_W].
- ch_data_in  in  NUM_CH*DATA_W  packed per-channel write data.
- ch_req_read  in  NUM_CH  level read request per channel.
- ch_req_write  in  NUM_CH  level write request per channel.
- ch_data_out  out  DATA_W  registered read data, shared by all channels; qualified by ch_data_valid.
- ch_data_valid  out  NUM_CH  one-cycle pulse to the granted channel on read completion.
- ch_write_complete  out  NUM_CH  one-cycle pulse to the granted channel on write completion.
- dram_addr  out  ADDR_W  address to the controller.
- dram_data_in  out  DATA_W  write data to the controller.
- dram_req_read  out  1  level read request to the controller.
- dram_req_write  out  1  level write request to the controller.
- dram_data_out  in  DATA_W  read data from the controller.
- dram_data_out_valid  in  1  read-complete pulse from the controller.
- dram_write_complete  in  1  write-complete pulse from the controller.
- err_timeout  out  1  one-cycle pulse when the watchdog aborts a transaction.
- err_ch  out  $clog2(NUM_CH)  channel that was aborted; held until the next abort.

Behaviour:

Reset:
- state=IDLE, rr_ptr=0, grant=0.
- All outputs 0, including dram_req_*, pulses, ch_data_out and err_ch.
- Reset mid-transaction drops dram_req_* on the next edge. Any late controller response arriving in IDLE is ignored.

Master handshake:
- A master holds its req_read or req_write level until its completion pulse arrives.
- It must deassert the request in the cycle after the pulse.
- A channel asserting both read and write is served as a read; the write is ignored.

FSM (registered outputs):
- IDLE
  - If any request is pending, grant = first requesting channel at or after rr_ptr, searching upward with wrap.
  - Latch that channel's addr, data and op into dram_addr, dram_data_in and dram_req_read/dram_req_write.
  - Go to BUSY.
  - Latency: request visible at edge n → dram_req_* high after edge n+1.
- BUSY
  - Hold dram_req_*, dram_addr and dram_data_in stable.
  - Read: on dram_data_out_valid, register dram_data_out into ch_data_out and pulse ch_data_valid[grant] for one cycle.
  - Write: on dram_write_complete, pulse ch_write_complete[grant] for one cycle.
  - On completion, dram_req_* drop to 0, rr_ptr = grant+1 mod NUM_CH, go to RELEASE.
  - A completion pulse of the wrong type (e.g. write_complete during a read) is ignored.
- RELEASE
  - One cycle, lets the master drop its request.
  - Requests sampled in this cycle are not arbitrated.
  - Go to IDLE.

Fairness and throughput:
- Minimum turnaround is 3 cycles beyond DRAM latency.
- With all channels requesting continuously, grants cycle 0,1,…,NUM_CH-1,0.
- ch_data_out holds its last value between reads.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in BUSY.
  - On reaching TIMEOUT_CYC-1 with no completion: drop dram_req_*, pulse err_timeout, set err_ch=grant, advance rr_ptr, go to RELEASE.
  - No completion pulse is given to the aborted channel.
  - The counter clears on entry to BUSY.
- Disabled:
  - No counter logic.
  - err_timeout and err_ch are tied to 0.
  - BUSY waits indefinitely.

Decomposition:
- Package bus_arb_pkg:
  - state enum {IDLE, BUSY, RELEASE}, 2 bits.
  - Default width constants ADDR_W_DEF=24 and DATA_W_DEF=32.
  - op encoding OP_READ=0, OP_WRITE=1.
- One sub-module rr_picker:
  - Combinational rotate-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: grant index and any_req.
- Everything else lives in bus_arbiter_n.

Test Plan:
1. Single read: ch2 read at addr 0x001234; controller returns 0xDEADBEEF 5 cycles after request → dram_addr=0x001234, ch_data_valid=4'b0100 for 1 cycle, ch_data_out=0xDEADBEEF, rr_ptr=3.
2. Contention, NUM_CH=4: all channels issue writes simultaneously and hold, re-requesting after each complete → ch_write_complete pulses in order ch0, ch1, ch2, ch3, ch0; no channel granted twice before the others.
3. Pointer wrap: rr_ptr=3, requests on ch1 and ch3 → ch3 granted first, then ch1, then rr_ptr=2.
4. Read+write both asserted on ch0 → dram_req_read=1, dram_req_write=0; ch_data_valid[0] pulses, ch_write_complete stays 0.
5. Reset asserted 2 cycles into BUSY → next cycle dram_req_*=0 and state IDLE; a late dram_data_out_valid produces no ch_data_valid pulse.
6. ARB_TIMEOUT_EN, TIMEOUT_CYC=16, controller silent on ch1 read → err_timeout pulses on cycle 16 of BUSY with err_ch=1; a following ch2 request is served normally.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state, op encoding and default widths for bus_arbiter_n
package bus_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 32;
   localparam logic OP_READ = 1'b0;
   localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/bus_arbiter_n_rr_picker.sv
// rr_picker: rotate-priority encoder returning the first requester at or after the pointer
module rr_picker #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         i_req,
   input  logic [$clog2(NUM_CH)-1:0] i_rr_ptr,
   output logic [$clog2(NUM_CH)-1:0] o_grant,
   output logic                      o_any_req
);
   // scan from the farthest offset down so the nearest requester after the pointer wins
   always_comb begin
      o_grant = '0;
      o_any_req = |i_req;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (i_req[(int'(i_rr_ptr) + k) % NUM_CH]) o_grant = $clog2(NUM_CH)'((int'(i_rr_ptr) + k) % NUM_CH);
   end
endmodule

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: round-robin sharing of one sdram_controller by NUM_CH masters; ARB_TIMEOUT_EN adds a BUSY watchdog
module bus_arbiter_n
   import bus_arb_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
   input  logic [NUM_CH*DATA_W-1:0]  ch_data_in,
   input  logic [NUM_CH-1:0]         ch_req_read,
   input  logic [NUM_CH-1:0]         ch_req_write,
   output logic [DATA_W-1:0]         ch_data_out,
   output logic [NUM_CH-1:0]         ch_data_valid,
   output logic [NUM_CH-1:0]         ch_write_complete,
   output logic [ADDR_W-1:0]         dram_addr,
   output logic [DATA_W-1:0]         dram_data_in,
   output logic                      dram_req_read,
   output logic                      dram_req_write,
   input  logic [DATA_W-1:0]         dram_data_out,
   input  logic                      dram_data_out_valid,
   input  logic                      dram_write_complete,
   output logic                      err_timeout,
   output logic [$clog2(NUM_CH)-1:0] err_ch
);
   localparam int W = $clog2(NUM_CH);
   localparam logic [W-1:0] LAST = W'(NUM_CH - 1);
   if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("bus_arbiter_n: unsupported NUM_CH or TIMEOUT_CYC");
   end
   state_t r_state;
   logic [W-1:0] r_rr_ptr, r_grant, w_grant, w_next;
   logic [NUM_CH-1:0] w_onehot;
   logic w_any_req, w_op, w_rd_done, w_wr_done;
   rr_picker #(.NUM_CH(NUM_CH)) u_picker (
      .i_req(ch_req_read | ch_req_write),
      .i_rr_ptr(r_rr_ptr),
      .o_grant(w_grant),
      .o_any_req(w_any_req)
   );
   assign w_op = ch_req_read[w_grant] ? OP_READ : OP_WRITE;
   assign w_next = (r_grant == LAST) ? '0 : r_grant + 1'b1;
   assign w_onehot = NUM_CH'(1) << r_grant;
   assign w_rd_done = dram_req_read & dram_data_out_valid;
   assign w_wr_done = dram_req_write & dram_write_complete;
`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   logic [CNT_W-1:0] r_cnt;
`else
   assign err_timeout = 1'b0;
   assign err_ch = '0;
`endif
   // arbitration FSM; every output is registered and completion pulses last one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rr_ptr <= '0;
         r_grant <= '0;
         dram_addr <= '0;
         dram_data_in <= '0;
         dram_req_read <= 1'b0;
         dram_req_write <= 1'b0;
         ch_data_out <= '0;
         ch_data_valid <= '0;
         ch_write_complete <= '0;
`ifdef ARB_TIMEOUT_EN
         r_cnt <= '0;
         err_timeout <= 1'b0;
         err_ch <= '0;
`endif
      end else begin
         ch_data_valid <= '0;
         ch_write_complete <= '0;
`ifdef ARB_TIMEOUT_EN
         err_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: if (w_any_req) begin
               r_grant <= w_grant;
               dram_addr <= ch_addr[w_grant*ADDR_W +: ADDR_W];
               dram_data_in <= ch_data_in[w_grant*DATA_W +: DATA_W];
               dram_req_read <= (w_op == OP_READ);
               dram_req_write <= (w_op == OP_WRITE);
`ifdef ARB_TIMEOUT_EN
               r_cnt <= '0;
`endif
               r_state <= BUSY;
            end
            BUSY: if (w_rd_done | w_wr_done) begin
               ch_data_valid <= w_rd_done ? w_onehot : '0;
               ch_write_complete <= w_wr_done ? w_onehot : '0;
               if (w_rd_done) ch_data_out <= dram_data_out;
               dram_req_read <= 1'b0;
               dram_req_write <= 1'b0;
               r_rr_ptr <= w_next;
               r_state <= RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               dram_req_read <= 1'b0;
               dram_req_write <= 1'b0;
               err_timeout <= 1'b1;
               err_ch <= r_grant;
               r_rr_ptr <= w_next;
               r_state <= RELEASE;
            end else r_cnt <= r_cnt + 1'b1;
`endif
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: table-driven transactions plus hand sequences for latency, reset abort and watchdog
module tb_bus_arbiter_n;
   logic clk = 1'b0, rst = 1'b1;
   logic [95:0] ch_addr = '0;
   logic [127:0] ch_data_in = '0;
   logic [3:0] ch_req_read = '0, ch_req_write = '0;
   logic [31:0] ch_data_out;
   logic [3:0] ch_data_valid, ch_write_complete;
   logic [23:0] dram_addr;
   logic [31:0] dram_data_in;
   logic dram_req_read, dram_req_write;
   logic [31:0] dram_data_out = '0;
   logic dram_data_out_valid = 1'b0, dram_write_complete = 1'b0;
   logic err_timeout;
   logic [1:0] err_ch;
   int n_vec = 0, n_bad = 0;
   typedef struct {
      logic [3:0] rd, wr;
      logic [23:0] addr;
      logic [31:0] wd, rdat;
      int dly, exp_ch;
      logic exp_rd;
   } vec_t;
   vec_t tbl[12];
   logic [31:0] last_rd = '0;
   bus_arbiter_n #(.NUM_CH(4), .ADDR_W(24), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .ch_addr(ch_addr), .ch_data_in(ch_data_in),
      .ch_req_read(ch_req_read), .ch_req_write(ch_req_write), .ch_data_out(ch_data_out),
      .ch_data_valid(ch_data_valid), .ch_write_complete(ch_write_complete),
      .dram_addr(dram_addr), .dram_data_in(dram_data_in), .dram_req_read(dram_req_read),
      .dram_req_write(dram_req_write), .dram_data_out(dram_data_out),
      .dram_data_out_valid(dram_data_out_valid), .dram_write_complete(dram_write_complete),
      .err_timeout(err_timeout), .err_ch(err_ch)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic [3:0] rd, input logic [3:0] wr, input logic [23:0] a, input logic [31:0] d, input int e);
      ch_req_read = rd;
      ch_req_write = wr;
      for (int c = 0; c < 4; c++) begin
         ch_addr[c*24 +: 24] = a ^ (24'(c ^ e) << 16);
         ch_data_in[c*32 +: 32] = d ^ (32'(c ^ e) << 24);
      end
   endtask
   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         ok = dram_req_read | dram_req_write;
      end
      if (!ok) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_req: no dram request within 20 cycles");
      end
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
   initial begin
      bit ok;
      int n;
      logic any;
      logic [3:0] m;
      for (int i = 0; i < 5; i++) tbl[i] = '{4'h0, 4'hF, 24'(24'h100000 + i), 32'(32'hA0000000 + i), 32'h0, 1 + i, i % 4, 1'b0};
      tbl[5]  = '{4'h4, 4'h0, 24'h001234, 32'h0, 32'hDEADBEEF, 5, 2, 1'b1};
      tbl[6]  = '{4'h0, 4'hA, 24'h003300, 32'h33330001, 32'h0, 2, 3, 1'b0};
      tbl[7]  = '{4'h0, 4'h2, 24'h001100, 32'h11110002, 32'h0, 1, 1, 1'b0};
      tbl[8]  = '{4'h1, 4'h4, 24'h002200, 32'h22220003, 32'h0, 3, 2, 1'b0};
      tbl[9]  = '{4'h1, 4'h0, 24'h000100, 32'h0, 32'h12345678, 2, 0, 1'b1};
      tbl[10] = '{4'h1, 4'h1, 24'h000200, 32'h77777777, 32'hCAFEF00D, 1, 0, 1'b1};
      tbl[11] = '{4'h3, 4'h0, 24'h000300, 32'h0, 32'h0BADF00D, 4, 1, 1'b1};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 64'({dram_req_read, dram_req_write}), 64'(0));
      chk("rst_pulses", 64'({ch_data_valid, ch_write_complete, err_timeout}), 64'(0));
      chk("rst_data", 64'({ch_data_out, dram_addr}), 64'(0));
      chk("rst_err_ch", 64'(err_ch), 64'(0));
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_ch);
         wait_req(ok);
         if (ok) begin
            m = 4'b1 << tbl[i].exp_ch;
            chk($sformatf("v%0d_addr", i), 64'(dram_addr), 64'(tbl[i].addr));
            chk($sformatf("v%0d_op", i), 64'({dram_req_read, dram_req_write}), 64'({tbl[i].exp_rd, ~tbl[i].exp_rd}));
            if (!tbl[i].exp_rd) chk($sformatf("v%0d_wdata", i), 64'(dram_data_in), 64'(tbl[i].wd));
            repeat (tbl[i].dly) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_hold", i), 64'({dram_req_read, dram_req_write, dram_addr, ch_data_valid, ch_write_complete}),
                64'({tbl[i].exp_rd, ~tbl[i].exp_rd, tbl[i].addr, 8'h00}));
            dram_data_out = tbl[i].rdat;
            dram_data_out_valid = tbl[i].exp_rd;
            dram_write_complete = ~tbl[i].exp_rd;
            @(posedge clk); #1;
            if (tbl[i].exp_rd) last_rd = tbl[i].rdat;
            chk($sformatf("v%0d_valid", i), 64'(ch_data_valid), 64'(tbl[i].exp_rd ? m : 4'h0));
            chk($sformatf("v%0d_wcomp", i), 64'(ch_write_complete), 64'(tbl[i].exp_rd ? 4'h0 : m));
            chk($sformatf("v%0d_dout", i), 64'(ch_data_out), 64'(last_rd));
            chk($sformatf("v%0d_drop", i), 64'({dram_req_read, dram_req_write}), 64'(0));
            @(negedge clk);
            dram_data_out_valid = 1'b0;
            dram_write_complete = 1'b0;
            ch_req_read[tbl[i].exp_ch] = 1'b0;
            ch_req_write[tbl[i].exp_ch] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse_end", i), 64'({ch_data_valid, ch_write_complete}), 64'(0));
            @(negedge clk);
         end
      end
      drive(4'h2, 4'h0, 24'h00ABCD, 32'h0, 1);
      @(posedge clk); #1;
      chk("lat_req", 64'({dram_req_read, dram_addr}), 64'({1'b1, 24'h00ABCD}));
      @(negedge clk) dram_write_complete = 1'b1;
      @(posedge clk); #1;
      chk("wrong_type", 64'({dram_req_read, ch_data_valid, ch_write_complete}), 64'({1'b1, 8'h00}));
      @(negedge clk);
      dram_write_complete = 1'b0;
      dram_data_out = 32'h55AA55AA;
      dram_data_out_valid = 1'b1;
      @(posedge clk); #1;
      chk("after_wrong_valid", 64'({ch_data_valid, ch_data_out}), 64'({4'h2, 32'h55AA55AA}));
      @(negedge clk);
      dram_data_out_valid = 1'b0;
      drive(4'h0, 4'h0, 24'h0, 32'h0, 0);
      @(negedge clk);
      drive(4'h8, 4'h0, 24'h00EEEE, 32'h0, 3);
      wait_req(ok);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_req", 64'({dram_req_read, dram_req_write}), 64'(0));
      chk("rst_mid_dout", 64'(ch_data_out), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      drive(4'h0, 4'h0, 24'h0, 32'h0, 0);
      dram_data_out = 32'h99999999;
      dram_data_out_valid = 1'b1;
      @(posedge clk); #1;
      chk("late_valid", 64'({ch_data_valid, ch_data_out}), 64'(0));
      @(negedge clk);
      dram_data_out_valid = 1'b0;
      drive(4'h0, 4'h4, 24'h004444, 32'h44440000, 2);
      @(posedge clk); #1;
      chk("post_rst_grant", 64'({dram_req_write, dram_addr, dram_data_in}), 64'({1'b1, 24'h004444, 32'h44440000}));
      @(negedge clk) dram_write_complete = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_wcomp", 64'(ch_write_complete), 64'(4'h4));
      @(negedge clk);
      dram_write_complete = 1'b0;
      drive(4'h0, 4'h0, 24'h0, 32'h0, 0);
      @(negedge clk);
      drive(4'h2, 4'h0, 24'h005555, 32'h0, 1);
      wait_req(ok);
`ifdef ARB_TIMEOUT_EN
      n = 0;
      for (int c = 1; c <= 40 && n == 0; c++) begin
         @(posedge clk); #1;
         if (err_timeout) n = c;
      end
      chk("to_cycle", 64'(n), 64'(16));
      chk("to_state", 64'({err_ch, dram_req_read, ch_data_valid}), 64'({2'd1, 5'h00}));
      @(posedge clk); #1;
      chk("to_pulse_end", 64'({err_timeout, err_ch}), 64'({1'b0, 2'd1}));
      @(negedge clk) drive(4'h4, 4'h0, 24'h006666, 32'h0, 2);
      wait_req(ok);
      chk("to_next_addr", 64'(dram_addr), 64'(24'h006666));
      m = 4'h4;
`else
      any = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         any |= err_timeout | (|ch_data_valid);
      end
      chk("no_to_quiet", 64'(any), 64'(0));
      chk("no_to_hold", 64'({dram_req_read, dram_addr}), 64'({1'b1, 24'h005555}));
      m = 4'h2;
`endif
      @(negedge clk);
      dram_data_out = 32'h0F0F0F0F;
      dram_data_out_valid = 1'b1;
      @(posedge clk); #1;
      chk("final_valid", 64'({ch_data_valid, ch_data_out, err_timeout}), 64'({m, 32'h0F0F0F0F, 1'b0}));
      @(negedge clk);
      dram_data_out_valid = 1'b0;
      drive(4'h0, 4'h0, 24'h0, 32'h0, 0);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
